memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 148 ++++++++++++++
 tb/tb_memory.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Memory stage: drives the dbus for loads/stores and aligns load data.
// Holds upstream via m_wait until the data phase completes.
module memory (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] alu_out_i,
  input  logic [63:0] srcb_i,
  input  logic [4:0]  dst_i,
  input  logic        regwrite_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [1:0]  msize_i,
  input  logic        mem_unsigned_i,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        valid_o,
  output logic [63:0] pc_o,
  output logic [63:0] result_o,
  output logic [4:0]  dst_o,
  output logic        regwrite_o,
  output logic        misalign_o,
  output logic        m_wait
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [63:0] ldata;
  logic [63:0] rsh;
  logic [63:0] lext;
  logic [7:0]  mask;
  logic [5:0]  sh;
  logic        aligned;
  logic        memacc;
  logic        memop;

  assign sh     = {alu_out_i[2:0], 3'b000};
  assign memacc = valid_i & (memread_i | memwrite_i);
  assign memop  = memacc & aligned;
  assign rsh    = dresp_data >> sh;

  always_comb begin
    aligned = 1'b1;
    mask    = 8'h01;
    lext    = {{56{~mem_unsigned_i & rsh[7]}}, rsh[7:0]};
    unique case (msize_i)
      2'd0: begin
        aligned = 1'b1;
        mask    = 8'h01;
        lext    = {{56{~mem_unsigned_i & rsh[7]}}, rsh[7:0]};
      end
      2'd1: begin
        aligned = (alu_out_i[0] == 1'b0);
        mask    = 8'h03;
        lext    = {{48{~mem_unsigned_i & rsh[15]}}, rsh[15:0]};
      end
      2'd2: begin
        aligned = (alu_out_i[1:0] == 2'b00);
        mask    = 8'h0F;
        lext    = {{32{~mem_unsigned_i & rsh[31]}}, rsh[31:0]};
      end
      default: begin
        aligned = (alu_out_i[2:0] == 3'b000);
        mask    = 8'hFF;
        lext    = rsh;
      end
    endcase
  end

  assign dreq_addr   = alu_out_i;
  assign dreq_size   = {1'b0, msize_i};
  assign dreq_data   = srcb_i << sh;
  assign dreq_strobe = memwrite_i ? (mask << alu_out_i[2:0]) : 8'h00;
  assign pc_o        = pc_i;
  assign dst_o       = dst_i;

  always_comb begin
    state_n    = state;
    dreq_valid = 1'b0;
    m_wait     = 1'b0;
    valid_o    = 1'b0;
    regwrite_o = 1'b0;
    misalign_o = 1'b0;
    result_o   = 64'd0;
    unique case (state)
      IDLE: begin
        if (memop) begin
          dreq_valid = 1'b1;
          m_wait     = 1'b1;
          state_n    = dresp_data_ok ? DONE : BUSY;
        end else if (valid_i) begin
          valid_o = 1'b1;
          if (memacc) begin
            misalign_o = 1'b1;
          end else begin
            result_o   = alu_out_i;
            regwrite_o = regwrite_i;
          end
        end
      end
      BUSY: begin
        dreq_valid = 1'b1;
        m_wait     = 1'b1;
        if (dresp_data_ok) state_n = DONE;
      end
      DONE: begin
        valid_o    = 1'b1;
        result_o   = memread_i ? ldata : alu_out_i;
        regwrite_o = regwrite_i & memread_i;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset quiets every outward signal in the same cycle it is seen.
    if (reset) begin
      state_n    = IDLE;
      dreq_valid = 1'b0;
      m_wait     = 1'b0;
      valid_o    = 1'b0;
      regwrite_o = 1'b0;
      misalign_o = 1'b0;
      result_o   = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ldata <= 64'd0;
    end else begin
      state <= state_n;
      if (dreq_valid & dresp_data_ok) ldata <= lext;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: stimulus pushes expected
// writeback records, a negedge monitor pops them when valid_o is seen.
module tb_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [63:0] pc_i;
  logic [63:0] alu_out_i;
  logic [63:0] srcb_i;
  logic [4:0]  dst_i;
  logic        regwrite_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [1:0]  msize_i;
  logic        mem_unsigned_i;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        valid_o;
  logic [63:0] pc_o;
  logic [63:0] result_o;
  logic [4:0]  dst_o;
  logic        regwrite_o;
  logic        misalign_o;
  logic        m_wait;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic [63:0] res;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t q[$];

  memory dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i),
    .alu_out_i(alu_out_i), .srcb_i(srcb_i), .dst_i(dst_i),
    .regwrite_i(regwrite_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .msize_i(msize_i),
    .mem_unsigned_i(mem_unsigned_i), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .valid_o(valid_o), .pc_o(pc_o),
    .result_o(result_o), .dst_o(dst_o), .regwrite_o(regwrite_o),
    .misalign_o(misalign_o), .m_wait(m_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (valid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got valid_o=1 expected none");
      end else begin
        e = q.pop_front();
        chk("wb_result", result_o, e.res);
        chk("wb_regwrite", {63'd0, regwrite_o}, {63'd0, e.rw});
        chk("wb_misalign", {63'd0, misalign_o}, {63'd0, e.mis});
        chk("wb_pc", pc_o, e.pc);
        chk("wb_dst", {59'd0, dst_o}, {59'd0, e.dst});
      end
    end
  end

  task automatic drive(input logic [63:0] pc, input logic [63:0] addr,
                       input logic [63:0] srcb, input logic [1:0] sz,
                       input logic rd, input logic wr, input logic uns,
                       input logic rw, input logic [4:0] dst);
    valid_i        = 1'b1;
    pc_i           = pc;
    alu_out_i      = addr;
    srcb_i         = srcb;
    msize_i        = sz;
    memread_i      = rd;
    memwrite_i     = wr;
    mem_unsigned_i = uns;
    regwrite_i     = rw;
    dst_i          = dst;
  endtask

  task automatic push(input logic [63:0] pc, input logic [4:0] dst,
                      input logic [63:0] res, input logic rw,
                      input logic mis);
    exp_t e;
    e.pc  = pc;
    e.dst = dst;
    e.res = res;
    e.rw  = rw;
    e.mis = mis;
    q.push_back(e);
  endtask

  // Single-cycle access: addr_ok and data_ok arrive with the request.
  task automatic memop(input logic [63:0] pc, input logic [63:0] addr,
                       input logic [63:0] srcb, input logic [63:0] rdata,
                       input logic [1:0] sz, input logic rd,
                       input logic wr, input logic uns,
                       input logic [4:0] dst, input logic [63:0] eres,
                       input logic erw, input logic [63:0] edata,
                       input logic [7:0] estrb);
    drive(pc, addr, srcb, sz, rd, wr, uns, 1'b1, dst);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = rdata;
    push(pc, dst, eres, erw, 1'b0);
    smp();
    chk("req_valid", {63'd0, dreq_valid}, 64'd1);
    chk("req_wait", {63'd0, m_wait}, 64'd1);
    chk("req_addr", dreq_addr, addr);
    chk("req_size", {61'd0, dreq_size}, {62'd0, sz});
    chk("req_strobe", {56'd0, dreq_strobe}, {56'd0, estrb});
    if (wr) chk("req_data", dreq_data, edata);
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    smp();
    chk("done_wait", {63'd0, m_wait}, 64'd0);
    chk("done_req", {63'd0, dreq_valid}, 64'd0);
    step();
    valid_i = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'd0;
    srcb_i        = 64'd0;
    drive(64'h10, 64'h55, 64'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    smp();
    chk("rst_req", {63'd0, dreq_valid}, 64'd0);
    chk("rst_wait", {63'd0, m_wait}, 64'd0);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_regwrite", {63'd0, regwrite_o}, 64'd0);
    step();
    reset = 1'b0;
    // ALU pass-through
    drive(64'h20, 64'h42, 64'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    push(64'h20, 5'd2, 64'h42, 1'b1, 1'b0);
    smp();
    chk("alu_wait", {63'd0, m_wait}, 64'd0);
    chk("alu_req", {63'd0, dreq_valid}, 64'd0);
    step();
    // Signed byte load, data_ok on the second BUSY cycle
    drive(64'h100, 64'h80000003, 64'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd7);
    smp();
    chk("lb_req", {63'd0, dreq_valid}, 64'd1);
    chk("lb_wait0", {63'd0, m_wait}, 64'd1);
    chk("lb_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("lb_valid_o", {63'd0, valid_o}, 64'd0);
    step();
    dresp_addr_ok = 1'b1;
    smp();
    chk("lb_wait1", {63'd0, m_wait}, 64'd1);
    chk("lb_addr1", dreq_addr, 64'h80000003);
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h00000000_80FF0000;
    push(64'h100, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    smp();
    chk("lb_wait2", {63'd0, m_wait}, 64'd1);
    step();
    dresp_data_ok = 1'b0;
    smp();
    chk("lb_done_wait", {63'd0, m_wait}, 64'd0);
    chk("lb_done_req", {63'd0, dreq_valid}, 64'd0);
    step();
    valid_i = 1'b0;
    smp();
    chk("idle_valid_o", {63'd0, valid_o}, 64'd0);
    step();
    memop(64'h200, 64'h80000006, 64'h1234, 64'd0, 2'd1, 1'b0, 1'b1,
          1'b0, 5'd3, 64'h80000006, 1'b0, 64'h1234_0000_0000_0000,
          8'hC0);
    // Misaligned word load
    drive(64'h240, 64'h80000002, 64'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd4);
    push(64'h240, 5'd4, 64'd0, 1'b0, 1'b1);
    smp();
    chk("mis_req", {63'd0, dreq_valid}, 64'd0);
    chk("mis_wait", {63'd0, m_wait}, 64'd0);
    step();
    valid_i = 1'b0;
    memop(64'h300, 64'h80000008, 64'd0, 64'h0123456789ABCDEF, 2'd3,
          1'b1, 1'b0, 1'b0, 5'd9, 64'h0123456789ABCDEF, 1'b1, 64'd0,
          8'h00);
    memop(64'h310, 64'h80000012, 64'd0, 64'h0000_0000_8001_0000, 2'd1,
          1'b1, 1'b0, 1'b1, 5'd10, 64'h8001, 1'b1, 64'd0, 8'h00);
    memop(64'h320, 64'h80000012, 64'd0, 64'h0000_0000_8001_0000, 2'd1,
          1'b1, 1'b0, 1'b0, 5'd11, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 64'd0,
          8'h00);
    memop(64'h330, 64'h80000014, 64'd0, 64'hF000_0000_0000_0000, 2'd2,
          1'b1, 1'b0, 1'b0, 5'd12, 64'hFFFF_FFFF_F000_0000, 1'b1, 64'd0,
          8'h00);
    memop(64'h340, 64'h80000014, 64'd0, 64'hF000_0000_0000_0000, 2'd2,
          1'b1, 1'b0, 1'b1, 5'd13, 64'h0000_0000_F000_0000, 1'b1, 64'd0,
          8'h00);
    memop(64'h350, 64'h80000003, 64'd0, 64'h0000_0000_80FF_0000, 2'd0,
          1'b1, 1'b0, 1'b1, 5'd14, 64'h80, 1'b1, 64'd0, 8'h00);
    memop(64'h360, 64'h80000025, 64'hAB, 64'd0, 2'd0, 1'b0, 1'b1, 1'b0,
          5'd15, 64'h80000025, 1'b0, 64'h0000_AB00_0000_0000, 8'h20);
    memop(64'h370, 64'h8000002C, 64'hDEADBEEF, 64'd0, 2'd2, 1'b0, 1'b1,
          1'b0, 5'd16, 64'h8000002C, 1'b0, 64'hDEADBEEF_0000_0000,
          8'hF0);
    memop(64'h380, 64'h80000030, 64'h1122334455667788, 64'd0, 2'd3,
          1'b0, 1'b1, 1'b0, 5'd17, 64'h80000030, 1'b0,
          64'h1122334455667788, 8'hFF);
    // Reset while BUSY, then a stray data_ok
    drive(64'h400, 64'h80000008, 64'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd18);
    smp();
    chk("rb_req0", {63'd0, dreq_valid}, 64'd1);
    step();
    smp();
    chk("rb_busy_wait", {63'd0, m_wait}, 64'd1);
    step();
    reset = 1'b1;
    smp();
    chk("rb_rst_req", {63'd0, dreq_valid}, 64'd0);
    chk("rb_rst_wait", {63'd0, m_wait}, 64'd0);
    chk("rb_rst_result", result_o, 64'd0);
    step();
    reset         = 1'b0;
    valid_i       = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hDEAD;
    smp();
    chk("rb_after_req", {63'd0, dreq_valid}, 64'd0);
    chk("rb_after_wait", {63'd0, m_wait}, 64'd0);
    chk("rb_after_valid", {63'd0, valid_o}, 64'd0);
    step();
    dresp_data_ok = 1'b0;
    drive(64'h500, 64'h99, 64'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd19);
    push(64'h500, 5'd19, 64'h99, 1'b0, 1'b0);
    smp();
    chk("rb_alu_wait", {63'd0, m_wait}, 64'd0);
    step();
    valid_i = 1'b0;
    step();
    step();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
